parallax_engine: RTL and testbench

Pixel-clocked, parametrised successor of the demo sine renderer. Draws NUM_LAYERS filled sine "terrain" layers, each scrolling at its own power-of-two speed, with per-layer dithering, frame-driven palette cycling and an optional fade state machine. Sits between the VGA timing generator (x, y, frame_active, v_sync) and the 2-bit-per-channel RGB output pins. Fully synchronous: v_sync is sampled, never used as a clock.

---
 rtl/parallax_pkg.sv | 32 +++
 rtl/parallax_engine_if.sv | 28 ++
 rtl/parallax_layer.sv | 40 ++++
 rtl/parallax_engine.sv | 163 ++++++++++++++++
 tb/tb_parallax_engine.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/parallax_pkg.sv
// Shared constants and types for parallax_engine.
//   SINE       : 64-entry 5-bit terrain profile, round(15.5 + 15.5*sin(2*pi*c/64))
//   PALETTE    : 8 RRGGBB colours (2 bits per channel)
//   fade_state_e : fade sequencer states (used when PARALLAX_FADE_EN is defined)
package parallax_pkg;

    localparam int unsigned MAX_LAYERS = 4;

    localparam logic [4:0] SINE [64] = '{
        5'd16, 5'd17, 5'd19, 5'd20, 5'd21, 5'd23, 5'd24, 5'd25,
        5'd26, 5'd27, 5'd28, 5'd29, 5'd30, 5'd30, 5'd31, 5'd31,
        5'd31, 5'd31, 5'd31, 5'd30, 5'd30, 5'd29, 5'd28, 5'd27,
        5'd26, 5'd25, 5'd24, 5'd23, 5'd21, 5'd20, 5'd19, 5'd17,
        5'd16, 5'd14, 5'd12, 5'd11, 5'd10, 5'd8,  5'd7,  5'd6,
        5'd5,  5'd4,  5'd3,  5'd2,  5'd1,  5'd1,  5'd0,  5'd0,
        5'd0,  5'd0,  5'd0,  5'd1,  5'd1,  5'd2,  5'd3,  5'd4,
        5'd5,  5'd6,  5'd7,  5'd8,  5'd10, 5'd11, 5'd12, 5'd14
    };

    localparam logic [5:0] PALETTE [8] = '{
        6'b110000, 6'b001100, 6'b000011, 6'b111100,
        6'b001111, 6'b110011, 6'b101010, 6'b111111
    };

    typedef enum logic [1:0] {FADE_IN, SHOW, FADE_OUT, BLANK} fade_state_e;

    // Clamp one 2-bit channel to the current intensity level.
    function automatic logic [1:0] chan_min(logic [1:0] chan, logic [1:0] level);
        return (chan < level) ? chan : level;
    endfunction

endpackage

// File: rtl/parallax_engine_if.sv
// Pixel bus between the VGA timing generator / output pins and parallax_engine.
//   master : timing side, drives x, y, frame_active, v_sync, layer_en, blank_req;
//            receives r, g, b, frame_ctr
//   slave  : the engine
interface parallax_if #(
    parameter int unsigned NUM_LAYERS = 3
);
    logic [9:0]            x;
    logic [8:0]            y;
    logic                  frame_active;
    logic                  v_sync;
    logic [NUM_LAYERS-1:0] layer_en;
    logic                  blank_req;
    logic [1:0]            r;
    logic [1:0]            g;
    logic [1:0]            b;
    logic [9:0]            frame_ctr;

    modport master (
        output x, y, frame_active, v_sync, layer_en, blank_req,
        input  r, g, b, frame_ctr
    );

    modport slave (
        input  x, y, frame_active, v_sync, layer_en, blank_req,
        output r, g, b, frame_ctr
    );
endinterface

// File: rtl/parallax_layer.sv
// One sine terrain layer: scroll, sine lookup, height compare and dither.
//   x_i, y_i     : current pixel
//   frame_ctr_i  : frame counter, scroll offset is frame_ctr << INDEX
//   en_i         : layer enable
//   hit_o        : pixel is covered by this layer (combinational)
module parallax_layer
    import parallax_pkg::*;
#(
    parameter int unsigned INDEX = 0
) (
    input  logic [9:0] x_i,
    input  logic [8:0] y_i,
    input  logic [9:0] frame_ctr_i,
    input  logic       en_i,
    output logic       hit_o
);
    logic [9:0] ax;
    logic [4:0] s;
    logic [5:0] thresh;
    logic       dither_ok;
    logic       unused_bits;

    always_comb begin
        ax     = x_i + (frame_ctr_i << INDEX);
        s      = SINE[ax[8:3]];
        // 6-bit compare so the 2*INDEX offset cannot wrap
        thresh = {1'b0, s} + 6'(2 * INDEX);
        if (INDEX == 0) begin
            dither_ok = 1'b1;
        end else if (INDEX % 2 == 1) begin
            dither_ok = x_i[0] ^ y_i[0];
        end else begin
            dither_ok = x_i[0] & y_i[0];
        end
        hit_o = en_i & dither_ok & ({1'b0, y_i[8:4]} >= thresh);
    end

    assign unused_bits = ^{ax[9], ax[2:0], y_i[3:1]};

endmodule

// File: rtl/parallax_engine.sv
// Parallax sine-terrain renderer with a 2-stage pixel pipeline.
//   clk, rst_n : pixel clock, synchronous active-low reset
//   bus        : parallax_if.slave (pixel coords, v_sync, layer_en, blank_req in;
//                registered r, g, b and frame_ctr out)
// Build option PARALLAX_FADE_EN: adds the fade sequencer driving the intensity
// level; without it the level is fixed at full and blank_req forces black.
module parallax_engine
    import parallax_pkg::*;
#(
    parameter int unsigned NUM_LAYERS   = 3,
    parameter int unsigned LATENCY_REGS = 2
) (
    input logic       clk,
    input logic       rst_n,
    parallax_if.slave bus
);
    if (LATENCY_REGS != 2) begin : g_bad_latency
        $error("parallax_engine supports LATENCY_REGS == 2 only");
    end
    if (NUM_LAYERS < 1 || NUM_LAYERS > MAX_LAYERS) begin : g_bad_layers
        $error("parallax_engine supports 1..4 layers");
    end

    logic                  vs_q;
    logic                  rise;
    logic [9:0]            frame_ctr_d, frame_ctr_q;
    logic [NUM_LAYERS-1:0] hit_raw, hit_q;
    logic [2:0]            pal_idx_d [NUM_LAYERS];
    logic [2:0]            pal_idx_q [NUM_LAYERS];
    logic                  active_q;
    logic [5:0]            colour;
    logic [5:0]            rgb_d, rgb_q;
    logic [1:0]            level;

    for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_layer
        parallax_layer #(
            .INDEX(i)
        ) u_layer (
            .x_i         (bus.x),
            .y_i         (bus.y),
            .frame_ctr_i (frame_ctr_q),
            .en_i        (bus.layer_en[i]),
            .hit_o       (hit_raw[i])
        );
    end

    always_comb begin
        rise        = bus.v_sync & ~vs_q;
        frame_ctr_d = rise ? frame_ctr_q + 10'd1 : frame_ctr_q;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            pal_idx_d[i] = 3'(i) + frame_ctr_q[7:5];
        end
    end

`ifdef PARALLAX_FADE_EN
    fade_state_e state_d, state_q;
    logic [1:0]  level_d, level_q;
    logic [3:0]  sub_d, sub_q;
    logic        wrap;

    // A blank_req-driven transition takes precedence; a coincident wrap does
    // not step the level, the next wrap steps in the new direction.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        sub_d   = rise ? sub_q + 4'd1 : sub_q;
        wrap    = rise && (sub_q == 4'd15);
        unique case (state_q)
            FADE_IN: begin
                if (bus.blank_req) begin
                    state_d = FADE_OUT;
                end else if (wrap) begin
                    if (level_q != 2'd3) level_d = level_q + 2'd1;
                    if (level_q >= 2'd2) state_d = SHOW;
                end
            end
            SHOW: begin
                if (bus.blank_req) begin
                    state_d = FADE_OUT;
                    sub_d   = 4'd0;
                end
            end
            FADE_OUT: begin
                if (!bus.blank_req) begin
                    state_d = FADE_IN;
                end else if (wrap) begin
                    if (level_q != 2'd0) level_d = level_q - 2'd1;
                    if (level_q <= 2'd1) state_d = BLANK;
                end
            end
            BLANK: begin
                if (!bus.blank_req) state_d = FADE_IN;
            end
            default: state_d = FADE_IN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FADE_IN;
            level_q <= 2'd0;
            sub_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            sub_q   <= sub_d;
        end
    end

    assign level = level_q;
`else
    logic blank_q;

    // blank travels with the pixel so it lines up with the 2-cycle latency
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blank_q <= 1'b0;
        end else begin
            blank_q <= bus.blank_req;
        end
    end

    assign level = 2'd3;
`endif

    always_comb begin
        colour = '0;
        // walk back to front so the lowest-index hit wins
        for (int i = int'(NUM_LAYERS) - 1; i >= 0; i--) begin
            if (hit_q[i]) colour = PALETTE[pal_idx_q[i]];
        end
        if (!active_q) colour = '0;
        rgb_d = {chan_min(colour[5:4], level), chan_min(colour[3:2], level),
                 chan_min(colour[1:0], level)};
`ifndef PARALLAX_FADE_EN
        if (blank_q) rgb_d = '0;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vs_q        <= 1'b0;
            frame_ctr_q <= '0;
            hit_q       <= '0;
            active_q    <= 1'b0;
            rgb_q       <= '0;
            for (int i = 0; i < NUM_LAYERS; i++) pal_idx_q[i] <= '0;
        end else begin
            vs_q        <= bus.v_sync;
            frame_ctr_q <= frame_ctr_d;
            hit_q       <= hit_raw;
            active_q    <= bus.frame_active;
            rgb_q       <= rgb_d;
            for (int i = 0; i < NUM_LAYERS; i++) pal_idx_q[i] <= pal_idx_d[i];
        end
    end

    assign bus.r         = rgb_q[5:4];
    assign bus.g         = rgb_q[3:2];
    assign bus.b         = rgb_q[1:0];
    assign bus.frame_ctr = frame_ctr_q;

endmodule

// File: tb/tb_parallax_engine.sv
// Self-checking bench for parallax_engine (NUM_LAYERS = 3). Follows the
// PARALLAX_FADE_EN build macro so the model matches the DUT configuration.
module tb_parallax_engine;
    localparam int NL = 3;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   chk_en = 1'b0;

    always #5 clk = ~clk;

    parallax_if #(.NUM_LAYERS(NL)) bus ();

    parallax_engine #(
        .NUM_LAYERS   (NL),
        .LATENCY_REGS (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- reference model ----------------
    logic [5:0] pal_m [8] = '{6'b110000, 6'b001100, 6'b000011, 6'b111100,
                              6'b001111, 6'b110011, 6'b101010, 6'b111111};

    typedef struct packed { int st; int lvl; int sub; } fade_t; // st: 0 in,1 show,2 out,3 blank

    int         m_ctr;
    bit         m_vs;
    logic [5:0] p1_col;
    bit         p1_blank;
    logic [5:0] m_out;
    fade_t      m_fade;

    function automatic int sine_m(int c);
        real v;
        v = 15.5 + 15.5 * $sin(2.0 * 3.14159265358979 * c / 64.0);
        return int'($floor(v + 0.5));
    endfunction

    function automatic logic [5:0] pix_m(int ctr, int xx, int yy, bit fa, bit [NL-1:0] en);
        if (!fa) return 6'd0;
        for (int i = 0; i < NL; i++) begin
            int ax;
            int s;
            bit pass;
            ax = (xx + ctr * (1 << i)) % 1024;
            s  = sine_m((ax / 8) % 64);
            if (i == 0) pass = 1'b1;
            else if (i % 2 == 1) pass = (xx % 2) != (yy % 2);
            else pass = (xx % 2 == 1) && (yy % 2 == 1);
            if (en[i] && pass && (yy / 16 >= s + 2 * i)) return pal_m[(i + (ctr / 32) % 8) % 8];
        end
        return 6'd0;
    endfunction

    function automatic logic [5:0] scale_m(logic [5:0] col, int lvl);
        logic [5:0] o;
        for (int c = 0; c < 3; c++) begin
            int v;
            v = (col >> (2 * c)) & 3;
            if (v > lvl) v = lvl;
            o[2*c +: 2] = 2'(v);
        end
        return o;
    endfunction

    function automatic fade_t fade_next(fade_t cur, bit rise, bit br);
        fade_t n;
        bit    took;
        bit    wrap;
        n    = cur;
        took = 1'b0;
        wrap = rise && cur.sub == 15;
        if (rise) n.sub = (cur.sub + 1) % 16;
        case (cur.st)
            0: if (br) begin n.st = 2; took = 1'b1; end
            1: if (br) begin n.st = 2; n.sub = 0; took = 1'b1; end
            2: if (!br) begin n.st = 0; took = 1'b1; end
            default: if (!br) begin n.st = 0; took = 1'b1; end
        endcase
        if (!took && wrap) begin
            if (n.st == 0) begin
                n.lvl = (cur.lvl < 3) ? cur.lvl + 1 : 3;
                if (n.lvl == 3) n.st = 1;
            end else if (n.st == 2) begin
                n.lvl = (cur.lvl > 0) ? cur.lvl - 1 : 0;
                if (n.lvl == 0) n.st = 3;
            end
        end
        return n;
    endfunction

`ifdef PARALLAX_FADE_EN
    localparam bit FADE = 1'b1;
`else
    localparam bit FADE = 1'b0;
`endif

    always @(posedge clk) begin
        if (!rst_n) begin
            m_ctr    <= 0;
            m_vs     <= 1'b0;
            p1_col   <= 6'd0;
            p1_blank <= 1'b0;
            m_out    <= 6'd0;
            m_fade   <= '{0, 0, 0};
        end else begin
            m_out    <= p1_blank ? 6'd0 : scale_m(p1_col, FADE ? m_fade.lvl : 3);
            p1_col   <= pix_m(m_ctr, int'(bus.x), int'(bus.y), bus.frame_active, bus.layer_en);
            p1_blank <= FADE ? 1'b0 : bus.blank_req;
            m_vs     <= bus.v_sync;
            if (bus.v_sync && !m_vs) m_ctr <= (m_ctr + 1) % 1024;
            m_fade   <= fade_next(m_fade, bus.v_sync && !m_vs, bus.blank_req);
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_rgb", int'({bus.r, bus.g, bus.b}), int'(m_out));
            check("model_frame_ctr", int'(bus.frame_ctr), m_ctr);
        end
    end

    task automatic drive_px(input int xx, input int yy, input bit fa, input bit [NL-1:0] en);
        @(negedge clk);
        bus.x            = 10'(xx);
        bus.y            = 9'(yy);
        bus.frame_active = fa;
        bus.layer_en     = en;
    endtask

    task automatic check_px(input string name, input int xx, input int yy, input bit fa,
                            input bit [NL-1:0] en, input logic [5:0] exp);
        drive_px(xx, yy, fa, en);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check(name, int'({bus.r, bus.g, bus.b}), int'(exp));
    endtask

    task automatic pulse(input int hold);
        @(negedge clk);
        bus.v_sync = 1'b1;
        repeat (hold) @(negedge clk);
        bus.v_sync = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic pulses(input int n);
        for (int k = 0; k < n; k++) pulse(1);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n            = 1'b0;
        bus.x            = '0;
        bus.y            = '0;
        bus.frame_active = 1'b0;
        bus.v_sync       = 1'b0;
        bus.layer_en     = '0;
        bus.blank_req    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        rst_n  = 1'b1;
        @(negedge clk);
        check("reset_rgb", int'({bus.r, bus.g, bus.b}), 0);
        check("reset_frame_ctr", int'(bus.frame_ctr), 0);

`ifndef PARALLAX_FADE_EN
        check_px("l0_hit", 0, 320, 1'b1, 3'b001, 6'b110000);
        check_px("l0_above", 0, 240, 1'b1, 3'b001, 6'b000000);
        check_px("l1_dither_on", 1, 320, 1'b1, 3'b010, 6'b001100);
        check_px("l1_dither_off", 0, 320, 1'b1, 3'b010, 6'b000000);
        check_px("priority", 0, 320, 1'b1, 3'b011, 6'b110000);
        check_px("l2_dither_on", 1, 321, 1'b1, 3'b100, 6'b000011);
        check_px("l2_dither_off", 1, 320, 1'b1, 3'b100, 6'b000000);
        check_px("inactive", 0, 320, 1'b0, 3'b011, 6'b000000);
        @(negedge clk);
        bus.blank_req = 1'b1;
        check_px("blank_forced", 0, 320, 1'b1, 3'b001, 6'b000000);
        @(negedge clk);
        bus.blank_req = 1'b0;
        check_px("blank_released", 0, 320, 1'b1, 3'b001, 6'b110000);

        // reset mid-frame: stage 1 is flushed, so black right after release
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_black", int'({bus.r, bus.g, bus.b}), 0);

        pulses(2);
        pulse(100);
        pulses(2);
        check("ctr_five", int'(bus.frame_ctr), 5);
        pulses(27);
        check("ctr_32", int'(bus.frame_ctr), 32);
        check_px("palette_cycled", 0, 400, 1'b1, 3'b001, 6'b001100);
        pulses(991);
        check("ctr_1023", int'(bus.frame_ctr), 1023);
        pulses(1);
        check("ctr_wrap", int'(bus.frame_ctr), 0);
`else
        check_px("fade_start_black", 0, 511, 1'b1, 3'b001, 6'b000000);
        pulses(16);
        @(negedge clk);
        check("fade_level1", int'({bus.r, bus.g, bus.b}), 6'b010000);
        pulses(32);
        @(negedge clk);
        check("fade_show", int'({bus.r, bus.g, bus.b}), 6'b001100);
        @(negedge clk);
        bus.blank_req = 1'b1;
        pulses(48);
        @(negedge clk);
        check("fade_blank", int'({bus.r, bus.g, bus.b}), 6'b000000);
        @(negedge clk);
        bus.blank_req = 1'b0;
        pulses(16);
        @(negedge clk);
        check("refade_level1", int'({bus.r, bus.g, bus.b}), 6'b010100);
        check("refade_ctr", int'(bus.frame_ctr), 112);
        @(negedge clk);
        bus.blank_req = 1'b1;
        pulses(20);
        @(negedge clk);
        check("fade_out_black", int'({bus.r, bus.g, bus.b}), 6'b000000);
`endif

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
